// File: rtl/sel_scan_pkg.sv
// Shared encodings for the selector channel-scan sequencer: FSM states,
// register map and CTRL bit positions.
package sel_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DWELL,
        S_NEXT,
        S_STOP
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RANGE  = 2'd1;
    localparam logic [1:0] REG_DWELL  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_SINGLE  = 1;
    localparam int CTRL_CLR_ERR = 2;

    // En sits at sel_data[CH_W + EN_OFS]
    localparam int EN_OFS         = 0;
    localparam int RANGE_LAST_LSB = 16;

endpackage

// File: rtl/sel_scan_regs.sv
// Configuration registers, shadow copies used by the scan FSM, and the
// combinational read-back mux.
module sel_scan_regs
    import sel_scan_pkg::*;
#(
    parameter int CH_W = 8,
    parameter int DW_W = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cfg_we,
    input  logic [1:0]      i_cfg_addr,
    input  logic [31:0]     i_cfg_wdata,
    input  logic            i_latch,
    input  logic            i_clr_run,
    input  logic [31:0]     i_status,
    output logic            o_run,
    output logic            o_single,
    output logic            o_clr_err,
    output logic [CH_W-1:0] o_first,
    output logic [CH_W-1:0] o_last,
    output logic [DW_W-1:0] o_dwell,
    output logic [31:0]     o_rdata
);

    logic [CH_W-1:0] r_first, r_last, r_last_sh;
    logic [DW_W-1:0] r_dwell, r_dwell_sh;
    logic            r_run, r_single;
    logic            w_wr_ctrl, w_wr_range, w_wr_dwell;
    logic            w_unused_ok;

    assign w_wr_ctrl   = i_cfg_we && (i_cfg_addr == REG_CTRL);
    assign w_wr_range  = i_cfg_we && (i_cfg_addr == REG_RANGE);
    assign w_wr_dwell  = i_cfg_we && (i_cfg_addr == REG_DWELL);
    assign w_unused_ok = &{1'b0, i_cfg_wdata};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run      <= 1'b0;
            r_single   <= 1'b0;
            r_first    <= '0;
            r_last     <= '0;
            r_dwell    <= '0;
            r_last_sh  <= '0;
            r_dwell_sh <= '0;
        end else begin
            // a bus write in the same cycle overrides the FSM's run clear
            if (i_clr_run) r_run <= 1'b0;
            if (w_wr_ctrl) begin
                r_run    <= i_cfg_wdata[CTRL_RUN];
                r_single <= i_cfg_wdata[CTRL_SINGLE];
            end
            if (w_wr_range) begin
                r_first <= i_cfg_wdata[CH_W-1:0];
                r_last  <= i_cfg_wdata[RANGE_LAST_LSB +: CH_W];
            end
            if (w_wr_dwell) r_dwell <= i_cfg_wdata[DW_W-1:0];
            if (i_latch) begin
                r_last_sh  <= r_last;
                r_dwell_sh <= r_dwell;
            end
        end
    end

    assign o_run     = r_run;
    assign o_single  = r_single;
    assign o_clr_err = w_wr_ctrl && i_cfg_wdata[CTRL_CLR_ERR];
    assign o_first   = r_first;
    assign o_last    = r_last_sh;
    assign o_dwell   = r_dwell_sh;

    always_comb begin
        o_rdata = '0;
        case (i_cfg_addr)
            REG_CTRL:  o_rdata = {30'b0, r_single, r_run};
            REG_RANGE: o_rdata = {16'(r_last), 16'(r_first)};
            REG_DWELL: o_rdata = 32'(r_dwell);
            default:   o_rdata = i_status;
        endcase
    end

endmodule

// File: rtl/sel_scan_sequencer.sv
// Autonomous channel-scan controller: steps the input mux selector through a
// programmed channel range and opens an acquisition window on each channel.
module sel_scan_sequencer
    import sel_scan_pkg::*;
#(
    parameter int              CH_W   = 8,
    parameter int              DW_W   = 16,
    parameter int              TO_W   = 16,
    parameter logic [TO_W-1:0] TO_MAX = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    output logic            sel_valid,
    output logic [31:0]     sel_data,
    input  logic            sel_active,
    output logic            acq_en,
    output logic [CH_W-1:0] acq_ch,
    output logic            frame_done,
    output logic            busy,
    output logic            err_timeout
);

    state_t          r_state, w_state_nxt;
    logic [CH_W-1:0] r_cur_ch;
    logic [DW_W-1:0] r_dw_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [15:0]     r_frame_cnt;
    logic            r_err;

    logic            w_run, w_single, w_clr_err;
    logic            w_latch, w_clr_run, w_to_set, w_frame_end;
    logic            w_busy, w_is_last, w_to_hit;
    logic [CH_W-1:0] w_first, w_last;
    logic [DW_W-1:0] w_dwell;
    logic [31:0]     w_status;

    assign w_busy    = (r_state != S_IDLE);
    assign w_is_last = (r_cur_ch == w_last);
    assign w_to_hit  = (r_to_cnt == TO_MAX);
    assign w_status  = {r_frame_cnt, 5'b0, r_err, w_busy, 9'(r_cur_ch)};

    sel_scan_regs #(.CH_W(CH_W), .DW_W(DW_W)) u_regs (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cfg_we   (cfg_we),
        .i_cfg_addr (cfg_addr),
        .i_cfg_wdata(cfg_wdata),
        .i_latch    (w_latch),
        .i_clr_run  (w_clr_run),
        .i_status   (w_status),
        .o_run      (w_run),
        .o_single   (w_single),
        .o_clr_err  (w_clr_err),
        .o_first    (w_first),
        .o_last     (w_last),
        .o_dwell    (w_dwell),
        .o_rdata    (cfg_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_clr_run   = 1'b0;
        w_to_set    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_latch = 1'b1;
                if (w_run) w_state_nxt = S_LOAD;
            end
            S_LOAD: w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (!w_run)          w_state_nxt = S_STOP;
                else if (sel_active) w_state_nxt = S_WAIT_LO;
                else if (w_to_hit) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_WAIT_LO: begin
                if (!w_run)           w_state_nxt = S_STOP;
                else if (!sel_active) w_state_nxt = S_DWELL;
                else if (w_to_hit) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_DWELL: if (r_dw_cnt == '0) w_state_nxt = S_NEXT;
            S_NEXT: begin
                // a cleared run lets the finished dwell stand but starts no new channel
                if (w_is_last) begin
                    w_frame_end = 1'b1;
                    if (w_single || !w_run) w_state_nxt = S_STOP;
                    else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end else if (!w_run) w_state_nxt = S_STOP;
                else                 w_state_nxt = S_LOAD;
            end
            S_STOP: begin
                w_clr_run   = w_single;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_ch    <= '0;
            r_dw_cnt    <= '0;
            r_to_cnt    <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_latch && w_state_nxt == S_LOAD)
                r_cur_ch <= w_first;
            else if (r_state == S_NEXT && w_state_nxt == S_LOAD)
                r_cur_ch <= r_cur_ch + 1'b1;

            if (r_state == S_LOAD)
                r_to_cnt <= '0;
            else if ((r_state == S_WAIT_HI || r_state == S_WAIT_LO) && !w_to_hit)
                r_to_cnt <= r_to_cnt + 1'b1;

            // a programmed dwell of 0 behaves as 1 cycle
            if (r_state == S_WAIT_LO && w_state_nxt == S_DWELL)
                r_dw_cnt <= (w_dwell == '0) ? '0 : w_dwell - 1'b1;
            else if (r_state == S_DWELL && r_dw_cnt != '0)
                r_dw_cnt <= r_dw_cnt - 1'b1;

            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 1'b1;

            if (w_clr_err)     r_err <= 1'b0;
            else if (w_to_set) r_err <= 1'b1;
        end
    end

    assign sel_valid   = (r_state == S_LOAD) || (r_state == S_STOP);
    assign acq_en      = (r_state == S_DWELL);
    assign acq_ch      = acq_en ? r_cur_ch : '0;
    assign frame_done  = w_frame_end;
    assign busy        = w_busy;
    assign err_timeout = r_err;

    always_comb begin
        sel_data = '0;
        if (r_state == S_LOAD) begin
            sel_data[CH_W+EN_OFS] = 1'b1;
            sel_data[CH_W-1:0]    = r_cur_ch;
        end
    end

endmodule

// File: tb/tb_sel_scan_sequencer.sv
// Scoreboard bench for sel_scan_sequencer: selector writes and acquisition
// windows are recorded by a monitor and compared against expected queues.
module tb_sel_scan_sequencer;

    localparam int          CH_W = 8;
    localparam logic [15:0] TOM  = 16'd40;

    logic        clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, sel_active = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [31:0] cfg_rdata, sel_data;
    logic        sel_valid, acq_en, frame_done, busy, err_timeout;
    logic [CH_W-1:0] acq_ch;

    always #5 clk = ~clk;

    sel_scan_sequencer #(.CH_W(CH_W), .DW_W(16), .TO_W(16), .TO_MAX(TOM)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .sel_valid(sel_valid),
        .sel_data(sel_data), .sel_active(sel_active), .acq_en(acq_en),
        .acq_ch(acq_ch), .frame_done(frame_done), .busy(busy),
        .err_timeout(err_timeout)
    );

    typedef struct packed { logic [7:0] ch; logic [15:0] len; } acq_t;

    int          n_pass = 0, n_chk = 0;
    logic [31:0] obs_sel[$], exp_sel[$];
    int          obs_cyc[$];
    acq_t        obs_acq[$], exp_acq[$];
    int          fd_cnt = 0, cyc = 0, cur_len = 0;
    logic [7:0]  cur_ch = 8'd0;
    bit          prev_sv = 0, dbl_sv = 0, ch_jump = 0, resp_en = 1;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (sel_valid === 1'b1) begin
            obs_sel.push_back(sel_data);
            obs_cyc.push_back(cyc);
            if (prev_sv) dbl_sv = 1;
        end
        prev_sv = (sel_valid === 1'b1);
        if (frame_done === 1'b1) fd_cnt++;
        if (acq_en === 1'b1) begin
            if (cur_len == 0) cur_ch = acq_ch;
            else if (acq_ch !== cur_ch) ch_jump = 1;
            cur_len++;
        end else if (cur_len > 0) begin
            acq_t a;
            a.ch = cur_ch; a.len = 16'(cur_len);
            obs_acq.push_back(a);
            cur_len = 0;
        end
    end

    // selector model: active rises ~3 cycles after an enabling write, for 2 cycles
    initial forever begin
        @(negedge clk);
        if (resp_en && sel_valid === 1'b1 && sel_data[CH_W] === 1'b1) begin
            repeat (3) @(posedge clk);
            #1 sel_active = 1'b1;
            repeat (2) @(posedge clk);
            #1 sel_active = 1'b0;
        end
    end

    task automatic tick;
        @(negedge clk); #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic clear_sb;
        repeat (10) tick;
        obs_sel.delete(); exp_sel.delete(); obs_cyc.delete();
        obs_acq.delete(); exp_acq.delete();
        fd_cnt = 0; dbl_sv = 0; ch_jump = 0;
    endtask

    task automatic wait_sel(input int n, input int bound, output bit ok);
        int k = 0;
        while (obs_sel.size() < n && k < bound) begin tick; k++; end
        ok = (obs_sel.size() >= n);
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin tick; k++; end
        ok = (busy === 1'b0);
    endtask

    task automatic push_acq(input logic [7:0] ch, input logic [15:0] len);
        acq_t a;
        a.ch = ch; a.len = len;
        exp_acq.push_back(a);
    endtask

    task automatic test_reset;
        n_chk++; if ({sel_valid, acq_en, frame_done, busy, err_timeout} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {sel_valid, acq_en, frame_done, busy, err_timeout});
        else n_pass++;
        n_chk++; if (sel_data !== 32'd0) $display("FAIL reset_sel_data: got %h want 0", sel_data); else n_pass++;
        n_chk++; if (acq_ch !== 8'd0) $display("FAIL reset_acq_ch: got %h want 0", acq_ch); else n_pass++;
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a); #1;
            n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL reset_reg%0d: got %h want 0", a, cfg_rdata); else n_pass++;
        end
        tick; rst = 1'b0; tick;
    endtask

    task automatic test_scan;
        bit ok; logic [31:0] o, e; acq_t oa, ea;
        clear_sb; resp_en = 1;
        cfg_write(2'd1, {16'd5, 16'd3});
        cfg_write(2'd2, 32'd4);
        cfg_write(2'd0, 32'd1);
        n_chk++; if (sel_valid !== 1'b0) $display("FAIL scan_latency1: sel_valid %b want 0", sel_valid); else n_pass++;
        tick;
        n_chk++; if (sel_valid !== 1'b1) $display("FAIL scan_latency2: sel_valid %b want 1", sel_valid); else n_pass++;
        exp_sel = '{32'h103, 32'h104, 32'h105, 32'h103};
        wait_sel(4, 400, ok);
        n_chk++; if (!ok) $display("FAIL scan_wait: got %0d writes want 4", obs_sel.size()); else n_pass++;
        cfg_write(2'd0, 32'd0);
        exp_sel.push_back(32'h0);
        wait_idle(50, ok);
        n_chk++; if (!ok) $display("FAIL scan_idle: busy %b want 0", busy); else n_pass++;
        push_acq(8'd3, 16'd4); push_acq(8'd4, 16'd4); push_acq(8'd5, 16'd4);
        while (exp_sel.size() > 0) begin
            e = exp_sel.pop_front(); o = (obs_sel.size() > 0) ? obs_sel.pop_front() : 32'hx;
            n_chk++; if (o !== e) $display("FAIL scan_sel: got %h want %h", o, e); else n_pass++;
        end
        while (exp_acq.size() > 0) begin
            ea = exp_acq.pop_front(); oa = (obs_acq.size() > 0) ? obs_acq.pop_front() : 'x;
            n_chk++; if (oa !== ea) $display("FAIL scan_acq: got ch %0d len %0d want ch %0d len %0d", oa.ch, oa.len, ea.ch, ea.len); else n_pass++;
        end
        n_chk++; if (obs_acq.size() != 0) $display("FAIL scan_acq_extra: got %0d extra want 0", obs_acq.size()); else n_pass++;
        n_chk++; if (fd_cnt != 1) $display("FAIL scan_frame_done: got %0d want 1", fd_cnt); else n_pass++;
        n_chk++; if ({dbl_sv, ch_jump} != 2'b00) $display("FAIL scan_protocol: got dbl %b jump %b want 0 0", dbl_sv, ch_jump); else n_pass++;
    endtask

    task automatic test_single;
        bit ok; logic [31:0] o, e; acq_t oa, ea;
        clear_sb;
        cfg_write(2'd1, {16'd7, 16'd7});
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd0, 32'd3);
        exp_sel = '{32'h107, 32'h0};
        push_acq(8'd7, 16'd1);
        wait_sel(2, 200, ok);
        n_chk++; if (!ok) $display("FAIL single_wait: got %0d writes want 2", obs_sel.size()); else n_pass++;
        wait_idle(20, ok); tick;
        n_chk++; if (!ok) $display("FAIL single_idle: busy %b want 0", busy); else n_pass++;
        while (exp_sel.size() > 0) begin
            e = exp_sel.pop_front(); o = (obs_sel.size() > 0) ? obs_sel.pop_front() : 32'hx;
            n_chk++; if (o !== e) $display("FAIL single_sel: got %h want %h", o, e); else n_pass++;
        end
        ea = exp_acq.pop_front(); oa = (obs_acq.size() > 0) ? obs_acq.pop_front() : 'x;
        n_chk++; if (oa !== ea) $display("FAIL single_acq: got ch %0d len %0d want ch 7 len 1", oa.ch, oa.len); else n_pass++;
        n_chk++; if (fd_cnt != 1) $display("FAIL single_frame_done: got %0d want 1", fd_cnt); else n_pass++;
        cfg_addr = 2'd0; #1;
        n_chk++; if (cfg_rdata !== 32'h2) $display("FAIL single_ctrl: got %h want 00000002", cfg_rdata); else n_pass++;
        cfg_addr = 2'd1; #1;
        n_chk++; if (cfg_rdata !== 32'h0007_0007) $display("FAIL single_range: got %h want 00070007", cfg_rdata); else n_pass++;
        cfg_addr = 2'd3; #1;
        n_chk++; if (cfg_rdata !== 32'h0002_0007) $display("FAIL single_status: got %h want 00020007", cfg_rdata); else n_pass++;
        cfg_write(2'd0, 32'd0);
    endtask

    task automatic test_timeout;
        bit ok; int gap; logic [31:0] o, e;
        clear_sb; resp_en = 0;
        cfg_write(2'd1, {16'd5, 16'd3});
        cfg_write(2'd2, 32'd1);
        cfg_write(2'd0, 32'd3);
        exp_sel = '{32'h103, 32'h0};
        wait_sel(2, 200, ok);
        n_chk++; if (!ok) $display("FAIL to_wait: got %0d writes want 2", obs_sel.size()); else n_pass++;
        gap = (obs_cyc.size() >= 2) ? obs_cyc[1] - obs_cyc[0] : -1;
        n_chk++; if (gap < int'(TOM) || gap > int'(TOM) + 3) $display("FAIL to_gap: got %0d want %0d..%0d", gap, TOM, TOM + 3); else n_pass++;
        wait_idle(20, ok);
        n_chk++; if (!ok) $display("FAIL to_idle: busy %b want 0", busy); else n_pass++;
        while (exp_sel.size() > 0) begin
            e = exp_sel.pop_front(); o = (obs_sel.size() > 0) ? obs_sel.pop_front() : 32'hx;
            n_chk++; if (o !== e) $display("FAIL to_sel: got %h want %h", o, e); else n_pass++;
        end
        n_chk++; if (obs_acq.size() != 0) $display("FAIL to_no_acq: got %0d windows want 0", obs_acq.size()); else n_pass++;
        repeat (10) tick;
        n_chk++; if (err_timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", err_timeout); else n_pass++;
        cfg_addr = 2'd3; #1;
        n_chk++; if (cfg_rdata[10] !== 1'b1) $display("FAIL to_status_err: got %b want 1", cfg_rdata[10]); else n_pass++;
        cfg_write(2'd0, 32'd4);
        n_chk++; if (err_timeout !== 1'b0) $display("FAIL to_clr_err: got %b want 0", err_timeout); else n_pass++;
        // set the flag again so the reset case has something to clear
        cfg_write(2'd0, 32'd3);
        tick;
        wait_idle(200, ok);
        n_chk++; if (!ok || err_timeout !== 1'b1) $display("FAIL to_rearm: busy %b err %b want 0 1", busy, err_timeout); else n_pass++;
        resp_en = 1;
    endtask

    task automatic test_wrap;
        bit ok; logic [31:0] o, e; acq_t oa, ea;
        clear_sb;
        cfg_write(2'd1, {16'd1, 16'd254});
        cfg_write(2'd2, 32'd2);
        cfg_write(2'd0, 32'd3);
        exp_sel = '{32'h1FE, 32'h1FF, 32'h100, 32'h101, 32'h0};
        push_acq(8'd254, 16'd2); push_acq(8'd255, 16'd2); push_acq(8'd0, 16'd2); push_acq(8'd1, 16'd2);
        wait_sel(5, 600, ok);
        n_chk++; if (!ok) $display("FAIL wrap_wait: got %0d writes want 5", obs_sel.size()); else n_pass++;
        wait_idle(20, ok);
        n_chk++; if (!ok) $display("FAIL wrap_idle: busy %b want 0", busy); else n_pass++;
        while (exp_sel.size() > 0) begin
            e = exp_sel.pop_front(); o = (obs_sel.size() > 0) ? obs_sel.pop_front() : 32'hx;
            n_chk++; if (o !== e) $display("FAIL wrap_sel: got %h want %h", o, e); else n_pass++;
        end
        while (exp_acq.size() > 0) begin
            ea = exp_acq.pop_front(); oa = (obs_acq.size() > 0) ? obs_acq.pop_front() : 'x;
            n_chk++; if (oa !== ea) $display("FAIL wrap_acq: got ch %0d len %0d want ch %0d len %0d", oa.ch, oa.len, ea.ch, ea.len); else n_pass++;
        end
        n_chk++; if (fd_cnt != 1) $display("FAIL wrap_frame_done: got %0d want 1", fd_cnt); else n_pass++;
        cfg_write(2'd0, 32'd0);
    endtask

    task automatic test_stop_dwell;
        bit ok; int k = 0; logic [31:0] o, e; acq_t oa, ea;
        clear_sb;
        cfg_write(2'd1, {16'd6, 16'd3});
        cfg_write(2'd2, 32'd6);
        cfg_write(2'd0, 32'd1);
        while (!(acq_en === 1'b1 && acq_ch === 8'd4) && k < 300) begin tick; k++; end
        n_chk++; if (acq_ch !== 8'd4) $display("FAIL stopd_reach: acq_ch %h want 04", acq_ch); else n_pass++;
        cfg_write(2'd0, 32'd0);
        wait_idle(50, ok); tick;
        n_chk++; if (!ok) $display("FAIL stopd_idle: busy %b want 0", busy); else n_pass++;
        exp_sel = '{32'h103, 32'h104, 32'h0};
        push_acq(8'd3, 16'd6); push_acq(8'd4, 16'd6);
        while (exp_sel.size() > 0) begin
            e = exp_sel.pop_front(); o = (obs_sel.size() > 0) ? obs_sel.pop_front() : 32'hx;
            n_chk++; if (o !== e) $display("FAIL stopd_sel: got %h want %h", o, e); else n_pass++;
        end
        n_chk++; if (obs_sel.size() != 0) $display("FAIL stopd_sel_extra: got %0d extra want 0", obs_sel.size()); else n_pass++;
        while (exp_acq.size() > 0) begin
            ea = exp_acq.pop_front(); oa = (obs_acq.size() > 0) ? obs_acq.pop_front() : 'x;
            n_chk++; if (oa !== ea) $display("FAIL stopd_acq: got ch %0d len %0d want ch %0d len %0d", oa.ch, oa.len, ea.ch, ea.len); else n_pass++;
        end
        n_chk++; if (fd_cnt != 0) $display("FAIL stopd_frame_done: got %0d want 0", fd_cnt); else n_pass++;
    endtask

    task automatic test_stop_waitlo;
        bit ok; int k = 0; logic [31:0] o, e;
        clear_sb;
        cfg_write(2'd2, 32'd3);
        cfg_write(2'd0, 32'd1);
        while (sel_active !== 1'b1 && k < 100) begin tick; k++; end
        n_chk++; if (sel_active !== 1'b1) $display("FAIL stopw_reach: sel_active %b want 1", sel_active); else n_pass++;
        cfg_write(2'd0, 32'd0);
        wait_idle(50, ok); repeat (3) tick;
        n_chk++; if (!ok) $display("FAIL stopw_idle: busy %b want 0", busy); else n_pass++;
        exp_sel = '{32'h103, 32'h0};
        while (exp_sel.size() > 0) begin
            e = exp_sel.pop_front(); o = (obs_sel.size() > 0) ? obs_sel.pop_front() : 32'hx;
            n_chk++; if (o !== e) $display("FAIL stopw_sel: got %h want %h", o, e); else n_pass++;
        end
        n_chk++; if (obs_acq.size() != 0 || cur_len != 0) $display("FAIL stopw_no_acq: got %0d windows want 0", obs_acq.size()); else n_pass++;
    endtask

    task automatic test_rst_mid_dwell;
        int k = 0;
        clear_sb;
        cfg_write(2'd2, 32'd8);
        cfg_write(2'd0, 32'd1);
        while (acq_en !== 1'b1 && k < 200) begin tick; k++; end
        n_chk++; if (acq_en !== 1'b1) $display("FAIL rst_reach: acq_en %b want 1", acq_en); else n_pass++;
        n_chk++; if (err_timeout !== 1'b1) $display("FAIL rst_pre_err: got %b want 1", err_timeout); else n_pass++;
        #1 rst = 1'b1; #1;
        n_chk++; if ({acq_en, sel_valid, busy, err_timeout} !== 4'b0)
            $display("FAIL rst_async: got %b want 0000", {acq_en, sel_valid, busy, err_timeout}); else n_pass++;
        tick; rst = 1'b0;
        repeat (5) tick;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_stay_idle: busy %b want 0", busy); else n_pass++;
        cfg_addr = 2'd3; #1;
        n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL rst_status: got %h want 0", cfg_rdata); else n_pass++;
        cfg_addr = 2'd0; #1;
        n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL rst_ctrl: got %h want 0", cfg_rdata); else n_pass++;
    endtask

    initial begin
        tick; tick;
        test_reset;
        test_scan;
        test_single;
        test_timeout;
        test_wrap;
        test_stop_dwell;
        test_stop_waitlo;
        test_rst_mid_dwell;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
